shared_mem_arbiter: RTL and testbench

Parametrised arbiter that multiplexes N requester ports onto one single-ported synchronous memory. It generalises the fixed instruction-fetch/data-access sharing of the pipelined CPU. Ports request with a hold-until-grant handshake, and reads return through a latency-tracking FSM. The arbiter sits between the CPU pipeline ports (IF, MEM, and future DMA/debug ports) and `memoria_compartilhada`. It provides fixed-priority or round-robin selection and per-port cancellation of in-flight reads, for pipeline flushes.

---
 rtl/shared_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Purpose : arbitrates N requester ports onto one single-ported synchronous memory.
// Latency : write grant 1 cycle after req seen in IDLE; read data/rvalid at 2+MEM_LAT.
// Backpr. : hold-until-grant; requests seen outside IDLE simply wait on their req line.
//
// Ports:
//   clock, reset         single clock, async active-high reset
//   req/we/addr/wdata    per-port request, held stable until gnt (addr/wdata packed by port)
//   cancel               drop the in-flight read owned by that port (pipeline flush)
//   gnt/rvalid           one-hot single-cycle pulses: access issued / rdata belongs to port
//   rdata, busy          registered read data shared by all ports; FSM not in IDLE
//   mem_*                memory side: address, write data, read/write strobes, read data
module shared_mem_arbiter #(
  parameter int N_PORTS  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         req,
  input  logic [N_PORTS-1:0]         we,
  input  logic [N_PORTS*ADDR_W-1:0]  addr,
  input  logic [N_PORTS*DATA_W-1:0]  wdata,
  input  logic [N_PORTS-1:0]         cancel,
  output logic [N_PORTS-1:0]         gnt,
  output logic [N_PORTS-1:0]         rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_rd,
  output logic                       mem_wr,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_win;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_we;
  logic               r_kill;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [CNT_W-1:0]   r_cnt;

  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic               w_found;
  logic               w_cnt_done;
  logic [N_PORTS-1:0] w_onehot;
  int                 w_idx;

  logic [ADDR_W-1:0]  w_addr_arr  [N_PORTS];
  logic [DATA_W-1:0]  w_wdata_arr [N_PORTS];

  // Unpack the flat per-port buses so the winner can be selected by index.
  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign w_addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
  end

  // Winner search: from index 0 in fixed mode, from r_ptr (wrapping) in round-robin.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      w_idx = (ARB_MODE == 1) ? int'(r_ptr) + k : k;
      if (w_idx >= N_PORTS) begin
        w_idx = w_idx - N_PORTS;
      end
      w_cand = IDX_W'(w_idx);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    w_ptr_nxt = '0;
    if (int'(w_sel) != N_PORTS - 1) begin
      w_ptr_nxt = w_sel + 1'b1;
    end
  end

  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (w_cnt_done) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win   <= '0;
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_kill  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      // The whole access is latched once so held req lines may change after gnt.
      if (r_state == S_IDLE && w_found) begin
        r_win   <= w_sel;
        r_we    <= we[w_sel];
        r_addr  <= w_addr_arr[w_sel];
        r_wdata <= w_wdata_arr[w_sel];
        if (ARB_MODE == 1) begin
          r_ptr <= w_ptr_nxt;
        end
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT && !w_cnt_done) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // mem_rdata is valid exactly on the last WAIT cycle.
      if (r_state == S_WAIT && w_cnt_done) begin
        r_rdata <= mem_rdata;
      end

      // Sticky kill: only the owner of an in-flight read can cancel it; the
      // memory latency still runs out so the next access starts on schedule.
      if (w_state_nxt == S_IDLE) begin
        r_kill <= 1'b0;
      end else if ((r_state == S_ISSUE || r_state == S_WAIT) && !r_we && cancel[r_win]) begin
        r_kill <= 1'b1;
      end
    end
  end

  assign w_onehot  = {{(N_PORTS-1){1'b0}}, 1'b1} << r_win;
  assign gnt       = (r_state == S_ISSUE) ? w_onehot : '0;
  assign rvalid    = (r_state == S_RESP && !r_kill) ? w_onehot : '0;
  assign busy      = (r_state != S_IDLE);
  assign mem_rd    = (r_state == S_ISSUE) && !r_we;
  assign mem_wr    = (r_state == S_ISSUE) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Purpose : directed checks of shared_mem_arbiter in three configurations.
// Latency : fixed-cycle stepping, outputs sampled 1 time unit after posedge.
// Backpr. : requests are held until the expected grant, then dropped.
module tb_shared_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // ---------------- DUT A: N=2, MEM_LAT=2, fixed priority
  logic [1:0]  a_req = '0, a_we = '0, a_cancel = '0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [1:0]  a_gnt, a_rvalid;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_busy, a_mem_rd, a_mem_wr;
  logic [31:0] a_p1, a_p2;

  shared_mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .ARB_MODE(0)) dut_a (
    .clock(clock), .reset(reset), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .cancel(a_cancel), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .busy(a_busy),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .mem_rdata(a_mem_rdata));

  always @(posedge clock) begin
    a_p1 <= a_mem_rd ? mem_f(a_mem_addr) : 32'hBAD0_BAD0;
    a_p2 <= a_p1;
  end
  assign a_mem_rdata = a_p2;

  // ---------------- DUT B: N=4, MEM_LAT=1, round-robin
  logic [3:0]   b_req = '0, b_we = '0, b_cancel = '0;
  logic [127:0] b_addr = '0, b_wdata = '0;
  logic [3:0]   b_gnt, b_rvalid;
  logic [31:0]  b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic         b_busy, b_mem_rd, b_mem_wr;
  logic [31:0]  b_p1;

  shared_mem_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .ARB_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .cancel(b_cancel), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .busy(b_busy),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_rdata(b_mem_rdata));

  always @(posedge clock) begin
    b_p1 <= b_mem_rd ? mem_f(b_mem_addr) : 32'hBAD1_BAD1;
  end
  assign b_mem_rdata = b_p1;

  // ---------------- DUT C: N=2, MEM_LAT=3, fixed priority
  logic [1:0]  c_req = '0, c_we = '0, c_cancel = '0;
  logic [63:0] c_addr = '0, c_wdata = '0;
  logic [1:0]  c_gnt, c_rvalid;
  logic [31:0] c_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;
  logic        c_busy, c_mem_rd, c_mem_wr;
  logic [31:0] c_p1, c_p2, c_p3;

  shared_mem_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .ARB_MODE(0)) dut_c (
    .clock(clock), .reset(reset), .req(c_req), .we(c_we), .addr(c_addr), .wdata(c_wdata),
    .cancel(c_cancel), .gnt(c_gnt), .rvalid(c_rvalid), .rdata(c_rdata), .busy(c_busy),
    .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_rd(c_mem_rd), .mem_wr(c_mem_wr),
    .mem_rdata(c_mem_rdata));

  always @(posedge clock) begin
    c_p1 <= c_mem_rd ? mem_f(c_mem_addr) : 32'hBAD2_BAD2;
    c_p2 <= c_p1;
    c_p3 <= c_p2;
  end
  assign c_mem_rdata = c_p3;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_ord [5];
    exp_ord = '{0, 1, 2, 3, 0};

    // ---- reset values
    tick(); tick();
    chk("rst_a_gnt", 64'(a_gnt), 64'h0);
    chk("rst_a_rvalid", 64'(a_rvalid), 64'h0);
    chk("rst_a_rdata", 64'(a_rdata), 64'h0);
    chk("rst_a_busy", 64'(a_busy), 64'h0);
    chk("rst_a_mem_rd", 64'(a_mem_rd), 64'h0);
    chk("rst_a_mem_wr", 64'(a_mem_wr), 64'h0);
    chk("rst_a_mem_addr", 64'(a_mem_addr), 64'h0);
    chk("rst_a_mem_wdata", 64'(a_mem_wdata), 64'h0);
    chk("rst_b_gnt", 64'(b_gnt), 64'h0);
    chk("rst_b_busy", 64'(b_busy), 64'h0);
    reset = 1'b0;
    tick();

    // ---- single read, port 1, MEM_LAT=2
    a_req = 2'b10; a_we = 2'b00; a_addr[63:32] = 32'h40;
    chk("rd_c0_busy", 64'(a_busy), 64'h0);
    tick();
    chk("rd_c1_gnt", 64'(a_gnt), 64'h2);
    chk("rd_c1_mem_rd", 64'(a_mem_rd), 64'h1);
    chk("rd_c1_mem_wr", 64'(a_mem_wr), 64'h0);
    chk("rd_c1_mem_addr", 64'(a_mem_addr), 64'h40);
    chk("rd_c1_busy", 64'(a_busy), 64'h1);
    a_req = 2'b00;
    tick();
    chk("rd_c2_gnt", 64'(a_gnt), 64'h0);
    chk("rd_c2_mem_rd", 64'(a_mem_rd), 64'h0);
    chk("rd_c2_rvalid", 64'(a_rvalid), 64'h0);
    tick();
    chk("rd_c3_rvalid", 64'(a_rvalid), 64'h0);
    tick();
    chk("rd_c4_rvalid", 64'(a_rvalid), 64'h2);
    chk("rd_c4_rdata", 64'(a_rdata), 64'hDEADBEEF);
    chk("rd_c4_busy", 64'(a_busy), 64'h1);
    tick();
    chk("rd_c5_busy", 64'(a_busy), 64'h0);
    chk("rd_c5_rvalid", 64'(a_rvalid), 64'h0);

    // ---- fixed priority, both ports writing
    a_req = 2'b11; a_we = 2'b11;
    a_addr = {32'h204, 32'h200}; a_wdata = {32'h2222_2222, 32'h1111_1111};
    tick();
    chk("fp_c1_gnt", 64'(a_gnt), 64'h1);
    chk("fp_c1_mem_wr", 64'(a_mem_wr), 64'h1);
    chk("fp_c1_mem_addr", 64'(a_mem_addr), 64'h200);
    chk("fp_c1_mem_wdata", 64'(a_mem_wdata), 64'h1111_1111);
    tick();
    chk("fp_c2_gnt", 64'(a_gnt), 64'h0);
    chk("fp_c2_busy", 64'(a_busy), 64'h0);
    tick();
    chk("fp_c3_gnt", 64'(a_gnt), 64'h1);
    tick();
    tick();
    chk("fp_c5_gnt", 64'(a_gnt), 64'h1);
    a_req = 2'b10;
    tick();
    chk("fp_c6_gnt", 64'(a_gnt), 64'h0);
    tick();
    chk("fp_c7_gnt", 64'(a_gnt), 64'h2);
    chk("fp_c7_mem_addr", 64'(a_mem_addr), 64'h204);
    chk("fp_c7_mem_wdata", 64'(a_mem_wdata), 64'h2222_2222);
    a_req = 2'b00;
    tick();
    chk("fp_c8_busy", 64'(a_busy), 64'h0);

    // ---- reset asserted in WAIT
    a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h80;
    tick();
    chk("rr_c1_gnt", 64'(a_gnt), 64'h1);
    a_req = 2'b00;
    tick();
    chk("rr_c2_busy", 64'(a_busy), 64'h1);
    reset = 1'b1;
    #1;
    chk("rst_mid_gnt", 64'(a_gnt), 64'h0);
    chk("rst_mid_rvalid", 64'(a_rvalid), 64'h0);
    chk("rst_mid_rdata", 64'(a_rdata), 64'h0);
    chk("rst_mid_busy", 64'(a_busy), 64'h0);
    chk("rst_mid_mem_rd", 64'(a_mem_rd), 64'h0);
    chk("rst_mid_mem_addr", 64'(a_mem_addr), 64'h0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_post_rvalid", 64'(a_rvalid), 64'h0);
    end
    a_req = 2'b10; a_we = 2'b10; a_addr[63:32] = 32'h300;
    tick();
    chk("rst_post_gnt", 64'(a_gnt), 64'h2);
    chk("rst_post_mem_addr", 64'(a_mem_addr), 64'h300);
    a_req = 2'b00;
    tick(); tick();

    // ---- round-robin, N=4, all ports writing
    for (int i = 0; i < 4; i++) begin
      b_addr[i*32 +: 32]  = 32'h100 + 32'(i);
      b_wdata[i*32 +: 32] = 32'hB000_0000 + 32'(i);
    end
    b_req = 4'hF; b_we = 4'hF;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("rb_gnt", 64'(b_gnt), 64'(4'b0001 << exp_ord[j]));
      chk("rb_mem_addr", 64'(b_mem_addr), 64'(32'h100 + 32'(exp_ord[j])));
      chk("rb_mem_wdata", 64'(b_mem_wdata), 64'(32'hB000_0000 + 32'(exp_ord[j])));
      tick();
      chk("rb_idle_gnt", 64'(b_gnt), 64'h0);
    end
    // ptr is now 1: ports 1 and 2 drop, so port 3 must win over port 0
    b_req = 4'b1001;
    tick();
    chk("rb_skip_gnt", 64'(b_gnt), 64'h8);
    tick();
    tick();
    chk("rb_wrap_gnt", 64'(b_gnt), 64'h1);
    b_req = 4'b0000;
    tick();

    // ---- round-robin DUT read, MEM_LAT=1
    b_req = 4'b0100; b_we = 4'b0000; b_addr[2*32 +: 32] = 32'h40;
    tick();
    chk("rb_rd_gnt", 64'(b_gnt), 64'h4);
    chk("rb_rd_mem_rd", 64'(b_mem_rd), 64'h1);
    b_req = 4'b0000;
    tick();
    chk("rb_rd_c2_rvalid", 64'(b_rvalid), 64'h0);
    tick();
    chk("rb_rd_rvalid", 64'(b_rvalid), 64'h4);
    chk("rb_rd_rdata", 64'(b_rdata), 64'hDEADBEEF);
    tick();
    chk("rb_rd_busy", 64'(b_busy), 64'h0);

    // ---- cancel by owner, MEM_LAT=3
    c_req = 2'b01; c_we = 2'b00; c_addr[31:0] = 32'h44;
    tick();
    chk("cn_c1_gnt", 64'(c_gnt), 64'h1);
    chk("cn_c1_mem_rd", 64'(c_mem_rd), 64'h1);
    c_req = 2'b00;
    tick();
    c_cancel = 2'b01;
    tick();
    c_cancel = 2'b00;
    c_req = 2'b10; c_we = 2'b10; c_addr[63:32] = 32'h500;
    chk("cn_c3_busy", 64'(c_busy), 64'h1);
    tick();
    chk("cn_c4_busy", 64'(c_busy), 64'h1);
    chk("cn_c4_rvalid", 64'(c_rvalid), 64'h0);
    tick();
    chk("cn_c5_rvalid", 64'(c_rvalid), 64'h0);
    chk("cn_c5_busy", 64'(c_busy), 64'h1);
    chk("cn_c5_gnt", 64'(c_gnt), 64'h0);
    tick();
    chk("cn_c6_busy", 64'(c_busy), 64'h0);
    chk("cn_c6_gnt", 64'(c_gnt), 64'h0);
    tick();
    chk("cn_c7_gnt", 64'(c_gnt), 64'h2);
    chk("cn_c7_mem_wr", 64'(c_mem_wr), 64'h1);
    chk("cn_c7_mem_addr", 64'(c_mem_addr), 64'h500);
    c_req = 2'b00;
    tick();

    // ---- cancel from a non-owner is ignored
    c_req = 2'b01; c_we = 2'b00; c_addr[31:0] = 32'h48; c_cancel = 2'b10;
    tick();
    chk("ig_c1_gnt", 64'(c_gnt), 64'h1);
    c_req = 2'b00;
    tick();
    tick();
    c_cancel = 2'b00;
    tick();
    chk("ig_c4_rvalid", 64'(c_rvalid), 64'h0);
    tick();
    chk("ig_c5_rvalid", 64'(c_rvalid), 64'h1);
    chk("ig_c5_rdata", 64'(c_rdata), 64'hA5A5_0048);
    tick();
    chk("ig_c6_busy", 64'(c_busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
